// File: rtl/reg_bank_param.sv
// Parameterised register bank: two combinational read ports, one write port, r0 hardwired to zero,
// sequenced bank clear. Define REG_BANK_PARAM_BYPASS_EN to forward accepted write data to matching reads.
module reg_bank_param #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              reg_write_enable,
   input  logic [ADDR_W-1:0] reg_write_dest,
   input  logic [DATA_W-1:0] reg_write_data,
   input  logic [ADDR_W-1:0] reg_read_addr_1,
   input  logic [ADDR_W-1:0] reg_read_addr_2,
   output logic [DATA_W-1:0] reg_read_data_1,
   output logic [DATA_W-1:0] reg_read_data_2,
   input  logic              clear_req,
   output logic              busy,
   output logic              clear_done,
   output logic              write_dropped
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

   logic [1:0]        state_reg;
   logic [1:0]        state_next;
   logic [ADDR_W-1:0] ptr_reg;
   logic [ADDR_W-1:0] ptr_next;
   logic              write_dropped_reg;
   logic              write_dest_nonzero;
   logic              write_accepted;
   logic              write_rejected;

   logic [DATA_W-1:0] regs_q  [DEPTH];
   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];

   assign write_dest_nonzero = (reg_write_dest != '0);
   assign write_accepted     = reg_write_enable && write_dest_nonzero && (state_reg == ST_IDLE);
   assign write_rejected     = reg_write_enable && write_dest_nonzero && (state_reg != ST_IDLE);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (clear_req) state_next = ST_CLEAR;
         ST_CLEAR: if (ptr_reg == PTR_LAST) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // ptr sits at 1 outside CLEAR so the first clear cycle always targets r1.
   assign ptr_next = ((state_reg == ST_CLEAR) && (ptr_reg != PTR_LAST)) ? ptr_reg + PTR_ONE : PTR_ONE;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg         <= ST_IDLE;
         ptr_reg           <= PTR_ONE;
         write_dropped_reg <= 1'b0;
      end else begin
         state_reg         <= state_next;
         ptr_reg           <= ptr_next;
         write_dropped_reg <= write_rejected;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign regs_q[gi] = '0;
         end else begin : g_store
            logic [DATA_W-1:0] value_reg;
            logic              clear_hit;
            logic              write_hit;

            assign clear_hit = (state_reg == ST_CLEAR) && (ptr_reg == ADDR_W'(gi));
            assign write_hit = write_accepted && (reg_write_dest == ADDR_W'(gi));

            always_ff @(posedge clock) begin
               if (reset) begin
                  value_reg <= '0;
               end else if (clear_hit) begin
                  value_reg <= '0;
               end else if (write_hit) begin
                  value_reg <= reg_write_data;
               end
            end

            assign regs_q[gi] = value_reg;
         end
      end
   endgenerate

   assign rd_addr[0] = reg_read_addr_1;
   assign rd_addr[1] = reg_read_addr_2;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         logic [DATA_W-1:0] data_mux;

         always_comb begin
            data_mux = regs_q[rd_addr[gi]];
`ifdef REG_BANK_PARAM_BYPASS_EN
            // write_accepted already excludes r0 and writes rejected by the clear sequence.
            if (write_accepted && (rd_addr[gi] == reg_write_dest)) begin
               data_mux = reg_write_data;
            end
`endif
         end

         assign rd_data[gi] = data_mux;
      end
   endgenerate

   assign reg_read_data_1 = rd_data[0];
   assign reg_read_data_2 = rd_data[1];
   assign busy            = (state_reg == ST_CLEAR);
   assign clear_done      = (state_reg == ST_DONE);
   assign write_dropped   = write_dropped_reg;

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed bench for reg_bank_param: default 8x8 bank plus a 16x16 bank for reset-during-clear.
// Expectations follow REG_BANK_PARAM_BYPASS_EN when it is defined for the build.
module tb_reg_bank_param;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   // default-parameter instance
   logic       reset, we, clear_req;
   logic [2:0] dest, ra1, ra2;
   logic [7:0] wdata, rd1, rd2;
   logic       busy, clear_done, write_dropped;

   // 16-bit / 16-deep instance
   logic        reset16, we16, clear_req16;
   logic [3:0]  dest16, ra1_16, ra2_16;
   logic [15:0] wdata16, rd1_16, rd2_16;
   logic        busy16, clear_done16, write_dropped16;

   int n_checks = 0;
   int n_fail   = 0;

   reg_bank_param dut (
      .clock(clock), .reset(reset),
      .reg_write_enable(we), .reg_write_dest(dest), .reg_write_data(wdata),
      .reg_read_addr_1(ra1), .reg_read_addr_2(ra2),
      .reg_read_data_1(rd1), .reg_read_data_2(rd2),
      .clear_req(clear_req), .busy(busy), .clear_done(clear_done),
      .write_dropped(write_dropped)
   );

   reg_bank_param #(.DATA_W(16), .ADDR_W(4)) dut16 (
      .clock(clock), .reset(reset16),
      .reg_write_enable(we16), .reg_write_dest(dest16), .reg_write_data(wdata16),
      .reg_read_addr_1(ra1_16), .reg_read_addr_2(ra2_16),
      .reg_read_data_1(rd1_16), .reg_read_data_2(rd2_16),
      .clear_req(clear_req16), .busy(busy16), .clear_done(clear_done16),
      .write_dropped(write_dropped16)
   );

   typedef struct {
      logic       we;
      logic [2:0] dest;
      logic [7:0] wdata;
      logic [2:0] ra1;
      logic [2:0] ra2;
      logic [7:0] exp1;
      logic [7:0] exp2;
      logic       exp_drop;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle8();
      we = 1'b0; dest = '0; wdata = '0; clear_req = 1'b0;
   endtask

   task automatic idle16();
      we16 = 1'b0; dest16 = '0; wdata16 = '0; clear_req16 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulses;
      logic [7:0] exp_byp;

      // r3 write, r0 write discarded, a few more writes and overwrite
      vecs[0] = '{1'b1, 3'd3, 8'hA5, 3'd1, 3'd2, 8'h00, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'hA5, 8'hA5, 1'b0};
      vecs[2] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd3, 8'h00, 8'hA5, 1'b0};
      vecs[3] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
      vecs[4] = '{1'b1, 3'd7, 8'h81, 3'd3, 3'd6, 8'hA5, 8'h00, 1'b0};
      vecs[5] = '{1'b1, 3'd1, 8'h11, 3'd7, 3'd3, 8'h81, 8'hA5, 1'b0};
      vecs[6] = '{1'b1, 3'd3, 8'h5A, 3'd1, 3'd0, 8'h11, 8'h00, 1'b0};
      vecs[7] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 8'h5A, 8'h81, 1'b0};

      idle8(); idle16();
      ra1 = '0; ra2 = '0; ra1_16 = '0; ra2_16 = '0;
      reset = 1'b1; reset16 = 1'b1;
      step(); step();
      reset = 1'b0; reset16 = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", clear_done, 0);
      check("rst_drop", write_dropped, 0);
      check("rst_rd1", rd1, 0);

      // table-driven vectors, IDLE state
      for (int i = 0; i < 8; i++) begin
         we = vecs[i].we; dest = vecs[i].dest; wdata = vecs[i].wdata;
         ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
         #1;
         $display("vec %0d: we=%0b dest=%0d data=%0h rd1=%0h rd2=%0h drop=%0b",
                  i, we, dest, wdata, rd1, rd2, write_dropped);
         check($sformatf("vec%0d_rd1", i), rd1, vecs[i].exp1);
         check($sformatf("vec%0d_rd2", i), rd2, vecs[i].exp2);
         check($sformatf("vec%0d_drop", i), write_dropped, vecs[i].exp_drop);
         step();
      end
      idle8();

      // same-cycle read of the register being written
`ifdef REG_BANK_PARAM_BYPASS_EN
      exp_byp = 8'h3C;
`else
      exp_byp = 8'h00;
`endif
      we = 1'b1; dest = 3'd2; wdata = 8'h3C; ra1 = 3'd2; ra2 = 3'd2;
      #1;
      $display("bypass: rd1=%0h rd2=%0h", rd1, rd2);
      check("byp_rd1", rd1, exp_byp);
      check("byp_rd2", rd2, exp_byp);
      step();
      idle8();
      #1;
      check("byp_next_rd1", rd1, 8'h3C);

      // fill r1..r7; the last write coincides with clear_req
      for (int i = 1; i < 8; i++) begin
         we = 1'b1; dest = 3'(i); wdata = 8'(8'h10 + i);
         clear_req = (i == 7);
         step();
      end
      idle8();

      for (int c = 1; c <= 8; c++) begin
         idle8();
         ra1 = 3'd5; ra2 = 3'd7;
         if (c == 2) clear_req = 1'b1;
         if (c == 3) begin we = 1'b1; dest = 3'd5; wdata = 8'h77; end
         #1;
         $display("clear cycle %0d: busy=%0b done=%0b drop=%0b r5=%0h r7=%0h",
                  c, busy, clear_done, write_dropped, rd1, rd2);
         check($sformatf("clr%0d_busy", c), busy, (c <= 7));
         check($sformatf("clr%0d_done", c), clear_done, (c == 8));
         check($sformatf("clr%0d_drop", c), write_dropped, (c == 4));
         if (c == 1) check("clr1_r7_old", rd2, 8'h17);
         if (c == 3) check("clr3_r5_old", rd1, 8'h15);
         if (c == 4) check("clr4_r5_old", rd1, 8'h15);
         step();
      end
      idle8();
      #1;
      check("post_busy", busy, 0);
      check("post_done", clear_done, 0);
      for (int i = 0; i < 8; i++) begin
         ra1 = 3'(i); ra2 = 3'(7 - i);
         #1;
         check($sformatf("post_r%0d", i), rd1, 0);
         check($sformatf("post_r%0d_p2", 7 - i), rd2, 0);
      end
      step();
      check("no_queued_clear", busy, 0);

      // 16-bit bank: reset in the 5th clear cycle
      for (int i = 1; i < 16; i++) begin
         we16 = 1'b1; dest16 = 4'(i); wdata16 = 16'(16'h1000 + i);
         clear_req16 = (i == 15);
         step();
      end
      idle16();
      for (int c = 1; c <= 5; c++) begin
         idle16();
         ra1_16 = 4'd10; ra2_16 = 4'd15;
         if (c == 5) begin
            reset16 = 1'b1;
            we16 = 1'b1; dest16 = 4'd9; wdata16 = 16'hBEEF;
         end
         #1;
         $display("clear16 cycle %0d: busy=%0b r10=%0h r15=%0h", c, busy16, rd1_16, rd2_16);
         check($sformatf("c16_%0d_busy", c), busy16, 1);
         if (c == 3) check("c16_r10_old", rd1_16, 16'h100A);
         step();
      end
      reset16 = 1'b0;
      idle16();
      #1;
      check("c16_rst_busy", busy16, 0);
      check("c16_rst_done", clear_done16, 0);
      check("c16_rst_drop", write_dropped16, 0);
      for (int i = 0; i < 16; i++) begin
         ra1_16 = 4'(i); ra2_16 = 4'(15 - i);
         #1;
         check($sformatf("c16_r%0d", i), rd1_16, 0);
         check($sformatf("c16_r%0d_p2", 15 - i), rd2_16, 0);
      end
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         if (clear_done16 || busy16) pulses++;
         step();
      end
      check("c16_no_done_pulse", pulses, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_bank_param.md
REG_BANK_PARAM -- requirements
Module: reg_bank_param

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the register and data width in bits.
REQ-002 Parameter ADDR_W, default 3, SHALL set the address width; the bank depth is DEPTH = 2^ADDR_W.
REQ-003 clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 reg_write_enable  input  1  SHALL request a write on this cycle.
REQ-006 reg_write_dest  input  ADDR_W  SHALL be the write destination index.
REQ-007 reg_write_data  input  DATA_W  SHALL be the write data.
REQ-008 reg_read_addr_1 / reg_read_addr_2  input  ADDR_W each  SHALL be the read port 1 and read port 2 indices.
REQ-009 reg_read_data_1 / reg_read_data_2  output  DATA_W each  SHALL be the read port 1 and read port 2 data.
REQ-010 clear_req  input  1  SHALL be a single-cycle request to start a sequenced bank clear.
REQ-011 busy  output  1  SHALL be high while the clear sequence is running.
REQ-012 clear_done  output  1  SHALL be a one-cycle pulse when the clear completes.
REQ-013 write_dropped  output  1  SHALL be a one-cycle pulse, registered on the edge, when a write request is rejected.

Function
REQ-014 Reads SHALL be combinational: read data follows the read address within the same cycle.
REQ-015 Register 0 SHALL always read as zero; writes addressed to register 0 SHALL be discarded without asserting write_dropped.
REQ-016 A write SHALL be accepted when reg_write_enable=1, the state is IDLE and reg_write_dest!=0; the stored value SHALL update on that edge.
REQ-017 The FSM SHALL have three states: IDLE, CLEAR and DONE.
REQ-018 Transitions SHALL be: IDLE->CLEAR on clear_req=1; CLEAR->DONE when ptr=DEPTH-1; DONE->IDLE unconditionally.
REQ-019 On entering CLEAR, the ADDR_W-bit ptr SHALL be 1; each CLEAR cycle SHALL zero reg[ptr] and then increment ptr.
REQ-020 The clear SHALL take exactly DEPTH-1 CLEAR cycles followed by 1 DONE cycle.
REQ-021 busy SHALL equal (state==CLEAR); clear_done SHALL equal (state==DONE).
REQ-022 While in CLEAR or DONE, every write request with reg_write_enable=1 and dest!=0 SHALL be discarded and SHALL produce write_dropped=1 on the next cycle.
REQ-023 A clear_req arriving in CLEAR or DONE SHALL be ignored and SHALL NOT be queued.
REQ-024 When clear_req and an accepted write occur together in IDLE, the write SHALL land, and the following clear SHALL zero that register.
REQ-025 Reads during CLEAR SHALL return the current stored contents, so registers not yet cleared return their old values.

Reset
REQ-026 When reset=1 at a rising edge, all DEPTH registers SHALL be zeroed and the state SHALL return to IDLE.
REQ-027 When reset=1 at a rising edge, ptr SHALL be 1 and busy, clear_done and write_dropped SHALL be 0.
REQ-028 Reset SHALL take priority over writes and clear_req on the same edge.
REQ-029 Reset asserted during CLEAR SHALL abort the sequence with no clear_done pulse.

Configuration
REQ-030 With macro REG_BANK_PARAM_BYPASS_EN defined, a read port whose address equals the destination of a write being accepted this cycle SHALL return reg_write_data combinationally.
REQ-031 With REG_BANK_PARAM_BYPASS_EN defined, register 0 SHALL never be bypassed and rejected writes SHALL never be bypassed.
REQ-032 Without REG_BANK_PARAM_BYPASS_EN, read ports SHALL return only stored contents, and a newly written value SHALL be visible from the cycle after the write.

Verification
REQ-033 Reset, then write 0xA5 to r3, then read r3 on both ports the next cycle -> 0xA5 on both ports.
REQ-034 Write 0xFF to r0 and read r0 -> 0x00, with write_dropped=0.
REQ-035 With defaults, fill r1..r7, pulse clear_req -> busy high for 7 cycles, clear_done high on the 8th cycle, then all registers read 0x00.
REQ-036 Write to r5 during the 3rd CLEAR cycle -> write_dropped pulses next cycle; r5 reads 0x00 after done.
REQ-037 Write 0x3C to r2 and read r2 in the same cycle -> 0x3C with the macro defined; old value without the macro, then 0x3C one cycle later.
REQ-038 With DATA_W=16 and ADDR_W=4, assert reset in the 5th CLEAR cycle -> no clear_done pulse, all 16 registers read 0x0000, busy=0 the next cycle.
